// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding and the queued command record.
package apb_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int ID_MAX_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS
  } apb_state_e;

  // The id field is sized for the largest supported slave count; the top zero-extends cmd_id.
  typedef struct packed {
    logic                write;
    logic [ID_MAX_W-1:0] id;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } apb_cmd_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue for the APB bridge: synchronous FIFO of apb_cmd_t with async reset.
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  apb_cmd_t i_data,
  output logic     o_full,
  input  logic     i_pop,
  output apb_cmd_t o_data,
  output logic     o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_cmd_t     r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: queues host commands and runs SETUP/ACCESS transfers with a one-cycle response pulse.
// Optional ACCESS-phase timeout abort is built when APB_TIMEOUT_EN is defined.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [id_width(NUM_SLAVES)-1:0] cmd_id,
  input  logic [ADDR_W-1:0]               cmd_addr,
  input  logic [DATA_W-1:0]               cmd_wdata,
  output logic                            rsp_valid,
  output logic                            rsp_write,
  output logic [DATA_W-1:0]               rsp_rdata,
  output logic                            rsp_err,
  output logic [NUM_SLAVES-1:0]           sel,
  output logic                            enable,
  output logic                            write,
  output logic [ADDR_W-1:0]               addr,
  output logic [DATA_W-1:0]               wdata,
  input  logic [DATA_W-1:0]               rdata,
  input  logic                            ready
);

  apb_state_e            r_state;
  apb_cmd_t              r_xfer;
  apb_cmd_t              w_push_cmd;
  apb_cmd_t              w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_done;
  logic                  w_timeout;
  logic [NUM_SLAVES-1:0] w_sel;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;

  // Gated by reset so the host sees cmd_ready=0 while the queue is held flushed.
  assign cmd_ready  = ~w_full & ~reset;
  assign w_push     = cmd_valid & cmd_ready;
  assign w_push_cmd = '{write: cmd_write, id: ID_MAX_W'(cmd_id), addr: cmd_addr, wdata: cmd_wdata};

  apb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_cmd),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty)
  );

  assign w_done = (r_state == ACCESS) && (ready || w_timeout);
  assign w_pop  = !w_empty && ((r_state == IDLE) || w_done);

`ifdef APB_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
  logic [WAIT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && !ready) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  // Abort on the TIMEOUT_CYCLES-th waited ACCESS cycle; ready on that cycle still wins.
  assign w_timeout = (r_state == ACCESS) && !ready && (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_xfer      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_xfer  <= w_head;
            r_state <= SETUP;
          end
        end
        SETUP: r_state <= ACCESS;
        ACCESS: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_xfer.write;
            r_rsp_err   <= w_timeout;
            r_rsp_rdata <= (w_timeout || r_xfer.write) ? '0 : rdata;
            if (!w_empty) begin
              r_xfer  <= w_head;
              r_state <= SETUP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_sel[i] = (r_xfer.id == ID_MAX_W'(i));
    end
  end

  // Bus fields come straight from the transfer register, so they hold their last value in IDLE.
  assign sel       = (r_state == IDLE) ? '0 : w_sel;
  assign enable    = (r_state == ACCESS);
  assign write     = r_xfer.write;
  assign addr      = r_xfer.addr;
  assign wdata     = r_xfer.wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: command table, random burst, and APB slave model.
module tb_apb_master_bridge;

  localparam int TIMEOUT_CYCLES = 16;

  typedef struct {
    logic       w;
    logic [1:0] id;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    int         waits;
    logic [3:0] exp_sel;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic       w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    int         waits;
  } bus_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_id;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] sel;
  logic       enable;
  logic       write;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;

  int   n_checks = 0;
  int   n_err    = 0;
  bus_t bus_q[$];
  logic [9:0] exp_q[$];
  logic s_active = 1'b0;
  int   s_cycles = 0;
  int   s_setups = 0;
  logic gap_mon  = 1'b0;
  int   gap_cnt  = 0;
  vec_t vecs[8];

  apb_master_bridge #(.NUM_SLAVES(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_id    (cmd_id),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sel       (sel),
    .enable    (enable),
    .write     (write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic w, input logic [1:0] id, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] rd, input int waits,
                          input logic [3:0] exp_sel, input logic [9:0] exp_rsp);
    int g = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_id    = id;
    cmd_addr  = a;
    cmd_wdata = wd;
    while (!cmd_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("push_accept", cmd_ready, 1'b1);
    bus_q.push_back('{exp_sel, w, a, wd, rd, waits});
    exp_q.push_back(exp_rsp);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size() + bus_q.size(), 0);
    @(negedge clk);
  endtask

  // Response scoreboard: every rsp_valid pulse consumes the oldest expected response.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 1'b0);
      else check("rsp", {rsp_write, rsp_err, rsp_rdata}, exp_q.pop_front());
    end
  end

  // APB slave model: checks SETUP/ACCESS fields against the queued command and inserts waits.
  always @(negedge clk) begin
    if (!reset) begin
      if (enable) begin
        if (bus_q.size() == 0) begin
          check("access_unexpected", bus_q.size(), 1);
        end else begin
          if (!s_active) begin
            s_active = 1'b1;
            s_cycles = 0;
            check("setup_cycles", s_setups, 1);
            s_setups = 0;
          end
          check("access_bus", {sel, write, addr, wdata},
                {bus_q[0].sel, bus_q[0].w, bus_q[0].addr, bus_q[0].wdata});
          s_cycles++;
          if (s_cycles > bus_q[0].waits) begin
            ready = 1'b1;
            rdata = bus_q[0].rd;
            void'(bus_q.pop_front());
            s_active = 1'b0;
          end else begin
            ready = 1'b0;
            rdata = 8'($urandom);
          end
        end
      end else begin
        ready = 1'($urandom_range(0, 1));
        rdata = 8'($urandom);
        if (s_active) begin
          s_active = 1'b0;
          void'(bus_q.pop_front());
`ifdef APB_TIMEOUT_EN
          check("timeout_len", s_cycles, TIMEOUT_CYCLES);
`else
          check("enable_drop", enable, 1'b1);
`endif
        end
        if (sel != 4'b0) begin
          s_setups++;
          if (bus_q.size() == 0) check("setup_unexpected", bus_q.size(), 1);
          else check("setup_bus", {sel, write, addr, wdata},
                     {bus_q[0].sel, bus_q[0].w, bus_q[0].addr, bus_q[0].wdata});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (gap_mon && sel == 4'b0 && bus_q.size() != 0) gap_cnt++;
  end

  initial begin
    logic       rw;
    logic [1:0] rid;
    logic [7:0] ra;
    logic [7:0] rwd;
    logic [7:0] rrd;
    int         rwait;
    int         g;

    vecs[0] = '{1'b1, 2'd1, 8'h06, 8'h05, 8'h00, 0, 4'b0010, 8'h00};
    vecs[1] = '{1'b0, 2'd1, 8'h06, 8'h00, 8'h05, 0, 4'b0010, 8'h05};
    vecs[2] = '{1'b1, 2'd0, 8'h05, 8'h04, 8'h00, 5, 4'b0001, 8'h00};
    vecs[3] = '{1'b0, 2'd3, 8'hFF, 8'h00, 8'hA5, 2, 4'b1000, 8'hA5};
    vecs[4] = '{1'b0, 2'd2, 8'h00, 8'h00, 8'h3C, 1, 4'b0100, 8'h3C};
    vecs[5] = '{1'b1, 2'd3, 8'h80, 8'hFF, 8'h99, 0, 4'b1000, 8'h00};
    vecs[6] = '{1'b0, 2'd0, 8'h7E, 8'h00, 8'hFF, 3, 4'b0001, 8'hFF};
    vecs[7] = '{1'b1, 2'd2, 8'h11, 8'h22, 8'h00, 0, 4'b0100, 8'h00};

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = 2'd0;
    cmd_addr = 8'h00; cmd_wdata = 8'h00; ready = 1'b0; rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_bus", {sel, enable, write, addr, wdata}, 0);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, 0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    #2 reset = 1'b0;
    #1 check("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Minimum-latency write: SETUP, single ACCESS, then response pulse.
    push_cmd(1'b1, 2'd1, 8'h06, 8'h05, 8'h00, 0, 4'b0010, {1'b1, 1'b0, 8'h00});
    @(negedge clk); check("t1_idle_sel", sel, 4'b0000);
    @(negedge clk); check("t1_setup", {sel, enable}, {4'b0010, 1'b0});
    @(negedge clk); check("t1_access", {sel, enable}, {4'b0010, 1'b1});
    @(negedge clk); check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_idle_after", {sel, enable}, 5'b0);
    @(negedge clk); check("t1_rsp_pulse", rsp_valid, 1'b0);

    for (int i = 0; i < 8; i++) begin
      push_cmd(vecs[i].w, vecs[i].id, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].waits,
               vecs[i].exp_sel, {vecs[i].w, 1'b0, vecs[i].exp_rdata});
      wait_drain(100);
    end

    // Fill the queue behind a stalled transfer, then check back-to-back flow and no push bypass.
    push_cmd(1'b1, 2'd0, 8'h40, 8'h01, 8'h00, 12, 4'b0001, {1'b1, 1'b0, 8'h00});
    push_cmd(1'b0, 2'd1, 8'h41, 8'h00, 8'h11, 0, 4'b0010, {1'b0, 1'b0, 8'h11});
    push_cmd(1'b1, 2'd2, 8'h42, 8'h03, 8'h00, 1, 4'b0100, {1'b1, 1'b0, 8'h00});
    push_cmd(1'b0, 2'd3, 8'h43, 8'h00, 8'h22, 0, 4'b1000, {1'b0, 1'b0, 8'h22});
    push_cmd(1'b1, 2'd1, 8'h44, 8'h05, 8'h00, 2, 4'b0010, {1'b1, 1'b0, 8'h00});
    @(negedge clk); check("t4_full_ready", cmd_ready, 1'b0);
    gap_cnt = 0; gap_mon = 1'b1;
    push_cmd(1'b0, 2'd0, 8'h45, 8'h00, 8'h33, 0, 4'b0001, {1'b0, 1'b0, 8'h33});
    wait_drain(300);
    gap_mon = 1'b0;
    check("t4_no_idle_gap", gap_cnt, 0);

    for (int i = 0; i < 20; i++) begin
      rw    = 1'($urandom_range(0, 1));
      rid   = 2'($urandom_range(0, 3));
      ra    = 8'($urandom_range(0, 255));
      rwd   = 8'($urandom_range(0, 255));
      rrd   = 8'($urandom_range(0, 255));
      rwait = $urandom_range(0, 3);
      push_cmd(rw, rid, ra, rwd, rrd, rwait, 4'b0001 << rid, {rw, 1'b0, rw ? 8'h00 : rrd});
    end
    wait_drain(500);

`ifdef APB_TIMEOUT_EN
    push_cmd(1'b0, 2'd2, 8'h33, 8'h00, 8'hEE, 1000, 4'b0100, {1'b0, 1'b1, 8'h00});
    push_cmd(1'b1, 2'd3, 8'h34, 8'h9A, 8'h00, 0, 4'b1000, {1'b1, 1'b0, 8'h00});
    wait_drain(200);
`endif

    // Reset while a transfer sits in ACCESS with another queued behind it.
    push_cmd(1'b0, 2'd2, 8'h5A, 8'h00, 8'h77, 40, 4'b0100, {1'b0, 1'b0, 8'h77});
    push_cmd(1'b1, 2'd3, 8'h5B, 8'h66, 8'h00, 0, 4'b1000, {1'b1, 1'b0, 8'h00});
    g = 0;
    while (!enable && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("t6_in_access", enable, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_sel_drop", sel, 4'b0000);
    check("t6_en_drop", enable, 1'b0);
    check("t6_cmd_ready_rst", cmd_ready, 1'b0);
    exp_q.delete(); bus_q.delete();
    s_active = 1'b0; s_setups = 0; s_cycles = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("t6_post_sel", sel, 4'b0000);
      check("t6_post_rsp", rsp_valid, 1'b0);
    end
    check("t6_cmd_ready", cmd_ready, 1'b1);
    push_cmd(1'b0, 2'd3, 8'hC3, 8'h00, 8'h5E, 1, 4'b1000, {1'b0, 1'b0, 8'h5E});
    wait_drain(100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
